// File: rtl/led_pkg.sv
// Shared encodings for the multi-channel LED sequencer.
package led_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF     = 2'd0;
    localparam mode_t MODE_STATIC  = 2'd1;
    localparam mode_t MODE_COUNT   = 2'd2;
    localparam mode_t MODE_BREATHE = 2'd3;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One LED output: duty latched at each PWM period start, registered compare.
module pwm_channel #(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic [PWM_WIDTH-1:0] pwm_cnt,
    input  logic                 period_start,
    input  logic [PWM_WIDTH-1:0] duty_in,
    output logic                 led
);

    logic [PWM_WIDTH-1:0] duty_q, duty_d;
    logic                 led_q, led_d;

    // duty_d doubles as the duty in force this cycle, so the first slot of a
    // period already compares against the freshly latched value.
    always_comb begin
        duty_d = duty_q;
        if (period_start) begin
            duty_d = duty_in;
        end
        led_d = Enable && (pwm_cnt < duty_d);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            duty_q <= '0;
            led_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/pwm_led_sequencer.sv
// Multi-channel LED driver: shared PWM counter, pattern tick divider,
// count / breathe sequencer and global brightness scaling.
//
// dir_q    | meaning
// DIR_UP   | breathe level ramping toward full scale
// DIR_DOWN | breathe level ramping toward zero
module pwm_led_sequencer
    import led_pkg::*;
#(
    parameter int CHANNELS     = 3,
    parameter int PWM_WIDTH    = 8,
    parameter int TICK_DIV     = 3571429,
    parameter int DIV_WIDTH    = 22,
    parameter int BREATHE_STEP = 8
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Enable,
    input  mode_t                         Mode,
    input  logic [PWM_WIDTH-1:0]          Brightness,
    input  logic [CHANNELS*PWM_WIDTH-1:0] Duty,
    output logic [CHANNELS-1:0]           Led,
    output logic [CHANNELS-1:0]           Step,
    output logic                          StepTick
);

    localparam logic [PWM_WIDTH-1:0] PWM_MAX  = '1;
    localparam logic [PWM_WIDTH-1:0] PWM_LAST = PWM_MAX - 1'b1;
    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(TICK_DIV - 1);
    localparam logic [PWM_WIDTH:0]   STEP_EXT = (PWM_WIDTH+1)'(BREATHE_STEP);
    localparam logic [PWM_WIDTH:0]   MAX_EXT  = {1'b0, PWM_MAX};

    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [CHANNELS-1:0]  step_q, step_d;
    logic [PWM_WIDTH-1:0] level_q, level_d;
    dir_e                 dir_q, dir_d;
    mode_t                mode_q, mode_d;
    logic [PWM_WIDTH:0]   up_sum, dn_diff;
    logic                 step_tick, mode_change, seq_clear, period_start;

    assign period_start = (pwm_cnt_q == '0);
    assign step_tick    = Enable && (div_q == DIV_LAST);
    assign mode_change  = (Mode != mode_q);
    assign seq_clear    = !Enable || mode_change;

    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
        mode_d    = Mode;
        step_d    = step_q;
        level_d   = level_q;
        dir_d     = dir_q;
        up_sum    = {1'b0, level_q} + STEP_EXT;
        dn_diff   = {1'b0, level_q} - STEP_EXT;

        if (seq_clear || div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        // A mode change clears the sequencer even when it lands on a tick.
        if (seq_clear) begin
            step_d  = '0;
            level_d = '0;
            dir_d   = DIR_UP;
        end else begin
            if (Mode != MODE_COUNT) begin
                step_d = '0;
            end else if (step_tick) begin
                step_d = step_q + 1'b1;
            end

            if (Mode == MODE_BREATHE && step_tick) begin
                if (dir_q == DIR_UP) begin
                    if (up_sum >= MAX_EXT) begin
                        level_d = PWM_MAX;
                        dir_d   = DIR_DOWN;
                    end else begin
                        level_d = up_sum[PWM_WIDTH-1:0];
                    end
                end else begin
                    if (dn_diff[PWM_WIDTH] || dn_diff == '0) begin
                        level_d = '0;
                        dir_d   = DIR_UP;
                    end else begin
                        level_d = dn_diff[PWM_WIDTH-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pwm_cnt_q <= '0;
            div_q     <= '0;
            step_q    <= '0;
            level_q   <= '0;
            dir_q     <= DIR_UP;
            mode_q    <= MODE_OFF;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            div_q     <= div_d;
            step_q    <= step_d;
            level_q   <= level_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [PWM_WIDTH-1:0]   duty_raw, duty_sel, duty_scaled, duty_eff;
        logic [2*PWM_WIDTH-1:0] duty_prod;

        assign duty_raw = Duty[gi*PWM_WIDTH +: PWM_WIDTH];

        always_comb begin
            duty_sel = '0;
            case (Mode)
                MODE_STATIC:  duty_sel = duty_raw;
                MODE_COUNT:   duty_sel = step_q[gi] ? PWM_MAX : '0;
                MODE_BREATHE: duty_sel = (duty_raw != '0) ? level_q : '0;
                default:      duty_sel = '0;
            endcase
        end

        assign duty_prod   = (2*PWM_WIDTH)'(duty_sel) * (2*PWM_WIDTH)'(Brightness);
        assign duty_scaled = PWM_WIDTH'(duty_prod >> PWM_WIDTH);
        assign duty_eff    = (Brightness == PWM_MAX) ? duty_sel : duty_scaled;

        pwm_channel #(
            .PWM_WIDTH(PWM_WIDTH)
        ) u_pwm_channel (
            .Clock       (Clock),
            .Reset       (Reset),
            .Enable      (Enable),
            .pwm_cnt     (pwm_cnt_q),
            .period_start(period_start),
            .duty_in     (duty_eff),
            .led         (Led[gi])
        );
    end

    assign Step     = step_q;
    assign StepTick = step_tick;

endmodule

// File: tb/tb_pwm_led_sequencer.sv
// Scoreboard bench for pwm_led_sequencer with a 4-bit PWM and a 4-clock tick.
module tb_pwm_led_sequencer;
    import led_pkg::*;

    localparam int CH = 3;
    localparam int PW = 4;
    localparam int TD = 4;
    localparam int DW = 2;
    localparam int BS = 4;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             Enable;
    mode_t            Mode;
    logic [PW-1:0]    Brightness;
    logic [CH*PW-1:0] Duty;
    logic [CH-1:0]    Led;
    logic [CH-1:0]    Step;
    logic             StepTick;

    pwm_led_sequencer #(
        .CHANNELS    (CH),
        .PWM_WIDTH   (PW),
        .TICK_DIV    (TD),
        .DIV_WIDTH   (DW),
        .BREATHE_STEP(BS)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Enable    (Enable),
        .Mode      (Mode),
        .Brightness(Brightness),
        .Duty      (Duty),
        .Led       (Led),
        .Step      (Step),
        .StepTick  (StepTick)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", obs, 32'hFFFF_FFFF);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic at_edge();
        @(posedge Clock);
        #1;
    endtask

    task automatic count_led(input int ncyc, output int c0, output int c1, output int c2);
        c0 = 0;
        c1 = 0;
        c2 = 0;
        repeat (ncyc) begin
            @(negedge Clock);
            c0 += int'(Led[0]);
            c1 += int'(Led[1]);
            c2 += int'(Led[2]);
        end
    endtask

    // Returns the number of sampled cycles until StepTick, or -1 on timeout.
    task automatic wait_tick(input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!StepTick && n < max_cyc);
        if (!StepTick) n = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, n, found;
        int breathe_exp[10];
        logic prev;

        breathe_exp = '{0, 4, 8, 12, 15, 11, 7, 3, 0, 4};

        Reset = 1'b0; Enable = 1'b0; Mode = MODE_OFF; Brightness = '1; Duty = '0;
        #1 Reset = 1'b1;
        @(negedge Clock);
        sb_push("rst_led", 0);  sb_pop(Led);
        sb_push("rst_step", 0); sb_pop(Step);
        sb_push("rst_tick", 0); sb_pop(StepTick);

        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0; Enable = 1'b1;
        sb_push("rst_release_tick_lat", TD);
        wait_tick(20, n); sb_pop(n);

        // STATIC, full brightness
        at_edge();
        Mode = MODE_STATIC; Brightness = 4'd15; Duty = {4'd15, 4'd8, 4'd0};
        sb_push("static_ch0", 0); sb_push("static_ch1", 8); sb_push("static_ch2", 15);
        repeat (30) @(negedge Clock);
        count_led(15, c0, c1, c2);
        sb_pop(c0); sb_pop(c1); sb_pop(c2);

        // mid-period duty change on ch1, right after its output falls
        found = 0;
        prev  = Led[1];
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge Clock);
            if (prev && !Led[1]) found = 1;
            prev = Led[1];
        end
        Duty[7:4] = 4'd12;
        sb_push("midper_fall_seen", 1); sb_pop(found);
        sb_push("midper_rest_ch1", 0);  sb_push("midper_next_ch1", 12);
        count_led(6, c0, c1, c2);  sb_pop(c1);
        count_led(15, c0, c1, c2); sb_pop(c1);

        // brightness scaling
        Brightness = 4'd8; Duty = {4'd15, 4'd8, 4'd0};
        sb_push("scale_ch0", 0); sb_push("scale_ch1", 4); sb_push("scale_ch2", 7);
        repeat (30) @(negedge Clock);
        count_led(15, c0, c1, c2);
        sb_pop(c0); sb_pop(c1); sb_pop(c2);

        // COUNT: step sequence with wrap, tick every TD cycles
        at_edge();
        Brightness = 4'd15; Mode = MODE_COUNT;
        @(negedge Clock);
        for (int k = 0; k < 9; k++) begin
            sb_push("count_tick_gap", TD);
            sb_push("count_step", k % 8);
            wait_tick(20, n);
            sb_pop(n);
            sb_pop(Step);
        end

        // drop Enable at Step=5 with a lit output
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge Clock);
            if (Step == 3'd5 && Led != '0) found = 1;
        end
        Enable = 1'b0;
        sb_push("step5_seen", 1); sb_pop(found);
        sb_push("dis_led", 0); sb_push("dis_step", 0); sb_push("dis_tick", 0);
        @(negedge Clock);
        sb_pop(Led); sb_pop(Step); sb_pop(StepTick);
        repeat (5) @(negedge Clock);
        at_edge();
        Enable = 1'b1;
        sb_push("reen_tick_lat", TD);
        wait_tick(20, n); sb_pop(n);

        // switch COUNT->BREATHE in the tick cycle, then follow the ramp
        Mode = MODE_BREATHE; Duty = {4'd15, 4'd8, 4'd1};
        for (int k = 0; k < 10; k++) begin
            sb_push("breathe_tick_gap", TD);
            sb_push("breathe_level", breathe_exp[k]);
            sb_push("breathe_step", 0);
            wait_tick(20, n);
            sb_pop(n);
            sb_pop(dut.level_q);
            sb_pop(Step);
        end

        Duty[3:0] = 4'd0;
        sb_push("breathe_zero_duty_ch0", 0);
        repeat (15) @(negedge Clock);
        count_led(30, c0, c1, c2); sb_pop(c0);

        // asynchronous reset mid-period with an output lit
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            @(negedge Clock);
            if (Led != '0) found = 1;
        end
        sb_push("lit_before_rst", 1); sb_pop(found);
        #2 Reset = 1'b1;
        #1;
        sb_push("async_rst_led", 0);   sb_pop(Led);
        sb_push("async_rst_step", 0);  sb_pop(Step);
        sb_push("async_rst_tick", 0);  sb_pop(StepTick);
        sb_push("async_rst_level", 0); sb_pop(dut.level_q);

        check_val("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
